// File: rtl/cory_sram_rd_port_pkg.sv
// ---------------------------------------------------------------------------
// cory_sram_rd_port_pkg
// Shared constants and helpers for the SRAM read-port adapter:
//   - cory_width()  : clog2-based width helper, never narrower than 1 bit
//   - cory_depth()  : output FIFO depth derived from the SRAM read latency
//   - C_MIN / C_MAX : legal range of the read latency parameter C
// ---------------------------------------------------------------------------
package cory_sram_rd_port_pkg;

  localparam int C_MIN = 1;
  localparam int C_MAX = 4;

  // Bits needed to index n items; a 1-item space still needs a 1-bit signal.
  function automatic int cory_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // One entry per in-flight pipeline stage plus one for the beat being
  // presented, which is what full throughput needs under same-cycle credit
  // return.
  function automatic int cory_depth(input int c);
    return c + 1;
  endfunction

endpackage : cory_sram_rd_port_pkg

// File: rtl/cory_sram_rd_fifo.sv
// ---------------------------------------------------------------------------
// cory_sram_rd_fifo
// DEPTH x D synchronous FIFO with wrap-around pointers (DEPTH need not be a
// power of two) and an occupancy count. Push and pop may happen in the same
// cycle. The caller guarantees it never pushes when full or pops when empty.
//
// Ports:
//   clk       in   clock, rising edge
//   reset_n   in   asynchronous active-low reset (pointers and count only)
//   i_push    in   write i_wdata at the tail
//   i_wdata   in   D-bit write data
//   i_pop     in   drop the head entry
//   o_rdata   out  D-bit head entry (undefined while empty)
//   o_count   out  current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module cory_sram_rd_fifo
  import cory_sram_rd_port_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int D     = 32,
  parameter int CW    = cory_width(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_push,
  input  logic [D-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [D-1:0]  o_rdata,
  output logic [CW-1:0] o_count
);

  localparam int PW = cory_width(DEPTH);

  logic [D-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;

  function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_count_nxt = r_count;
    case ({i_push, i_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= f_next_ptr(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= f_next_ptr(r_rd_ptr);
      r_count <= w_count_nxt;
    end
  end

  // NOTE: the storage array is deliberately not reset; the count and
  // pointers decide which entries are valid, so clearing data is wasted logic.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule : cory_sram_rd_fifo

// File: rtl/cory_sram_rd_port.sv
// ---------------------------------------------------------------------------
// cory_sram_rd_port
// Read-only SRAM access adapter. Active-low read commands from a requester are
// issued to a fixed-latency single-port SRAM read interface; returned data is
// queued in a small FIFO and presented as a valid/ready stream. A credit
// counter (in-flight reads + FIFO occupancy) keeps the FIFO from overflowing
// when the consumer stalls.
//
// Parameters: A address width, D data width, C SRAM read latency (1..4).
//
// Ports:
//   clk, reset_n      clock (rising edge), asynchronous active-low reset
//   i_s_cen           active-low read request
//   i_s_oen           active-low output-enable hint, merged onto o_z_oen
//   i_s_addr [A]      read address
//   o_s_r             request ready (read accepted when !i_s_cen & o_s_r)
//   o_z_cen           active-low SRAM read enable
//   o_z_oen           active-low SRAM output enable
//   o_z_addr [A]      SRAM address (pass-through of i_s_addr)
//   i_z_rdata [D]     SRAM read data, valid C cycles after issue
//   i_z_r             SRAM ready (read issued when !o_z_cen & i_z_r)
//   o_d_v / o_d_d [D] output stream valid / data (FIFO head)
//   i_d_r             output stream ready
//
// Optional: define CORY_SRAM_RO_CHECK_EN (simulation only) to enable a
// protocol checker reporting FIFO overflow/underflow, credit overrun and X
// data captured from the SRAM.
// ---------------------------------------------------------------------------
module cory_sram_rd_port
  import cory_sram_rd_port_pkg::*;
#(
  parameter int A = 8,
  parameter int D = 32,
  parameter int C = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_s_cen,
  input  logic         i_s_oen,
  input  logic [A-1:0] i_s_addr,
  output logic         o_s_r,
  output logic         o_z_cen,
  output logic         o_z_oen,
  output logic [A-1:0] o_z_addr,
  input  logic [D-1:0] i_z_rdata,
  input  logic         i_z_r,
  output logic         o_d_v,
  output logic [D-1:0] o_d_d,
  input  logic         i_d_r
);

  localparam int DEPTH = cory_depth(C);
  localparam int CW    = cory_width(DEPTH + 1);

  logic [C-1:0]  r_pipe;          // bit k set: a read issued k+1 cycles ago
  logic [C:0]    w_pipe_in;
  logic [CW-1:0] r_outstanding;   // in-flight reads + FIFO occupancy
  logic [CW-1:0] w_out_after_pop;
  logic [CW-1:0] w_count;
  logic          w_pop;
  logic          w_credit_ok;
  logic          w_issue;
  logic          w_stage_c;

  // A beat leaving this cycle frees its slot immediately, so the consumer's
  // ready reaches o_s_r / o_z_cen combinationally.
  assign w_pop           = o_d_v & i_d_r;
  assign w_out_after_pop = r_outstanding - CW'(w_pop);
  assign w_credit_ok     = w_out_after_pop < CW'(DEPTH);

  // o_z_cen must not depend on i_z_r: the SRAM may derive i_z_r from o_z_cen.
  assign o_z_cen  = i_s_cen | ~w_credit_ok;
  assign o_s_r    = i_z_r & w_credit_ok;
  assign w_issue  = ~o_z_cen & i_z_r;
  assign o_z_addr = i_s_addr;

  // The last pipeline stage marks the cycle the SRAM drives read data; it is
  // the only thing that captures i_z_rdata.
  assign w_stage_c = r_pipe[C-1];
  assign o_z_oen   = i_s_oen & ~w_stage_c;

  // Extra low bit makes the shift legal for C == 1 without a special case.
  assign w_pipe_in = {r_pipe, w_issue};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pipe        <= '0;
      r_outstanding <= '0;
    end else begin
      r_pipe        <= w_pipe_in[C-1:0];
      r_outstanding <= w_out_after_pop + CW'(w_issue);
    end
  end

  cory_sram_rd_fifo #(
    .DEPTH (DEPTH),
    .D     (D),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_stage_c),
    .i_wdata (i_z_rdata),
    .i_pop   (w_pop),
    .o_rdata (o_d_d),
    .o_count (w_count)
  );

  assign o_d_v = (w_count != '0);

`ifdef CORY_SRAM_RO_CHECK_EN
  always @(posedge clk) begin
    if (reset_n) begin
      if (C < C_MIN || C > C_MAX) begin
        $display("ERROR: %m read latency C=%0d out of range at %0t", C, $time);
        #100 $finish;
      end
      if (w_stage_c && !w_pop && w_count == CW'(DEPTH)) begin
        $display("ERROR: %m push to full FIFO at %0t", $time);
        #100 $finish;
      end
      if (w_pop && w_count == '0) begin
        $display("ERROR: %m pop from empty FIFO at %0t", $time);
        #100 $finish;
      end
      if (r_outstanding > CW'(DEPTH)) begin
        $display("ERROR: %m outstanding %0d exceeds depth %0d at %0t",
                 r_outstanding, DEPTH, $time);
        #100 $finish;
      end
      if (w_stage_c && $isunknown(i_z_rdata)) begin
        $display("ERROR: %m X on i_z_rdata captured at %0t", $time);
        #100 $finish;
      end
    end
  end
`endif

endmodule : cory_sram_rd_port

// File: tb/tb_cory_sram_rd_port.sv
// ---------------------------------------------------------------------------
// tb_cory_sram_rd_port
// Two instances: u_dut1 with C=1 (FIFO depth 2) and u_dut2 with C=3 (depth 4).
// u_dut1 runs a cycle-by-cycle vector table, a 16-read burst and a reset with
// reads in flight; u_dut2 checks the longer latency and its credit limit.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_cory_sram_rd_port;

  logic        clk;
  logic        reset_n;

  logic        cen1, oen1, z_r1, d_r1;
  logic [7:0]  addr1;
  logic [31:0] rdata1;
  logic        s_r1, z_cen1, z_oen1, d_v1;
  logic [7:0]  z_addr1;
  logic [31:0] d_d1;

  logic        cen2, oen2, z_r2, d_r2;
  logic [7:0]  addr2;
  logic [31:0] rdata2;
  logic        s_r2, z_cen2, z_oen2, d_v2;
  logic [7:0]  z_addr2;
  logic [31:0] d_d2;

  int n_checks = 0;
  int n_fail   = 0;

  cory_sram_rd_port #(.A(8), .D(32), .C(1)) u_dut1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_s_cen   (cen1),
    .i_s_oen   (oen1),
    .i_s_addr  (addr1),
    .o_s_r     (s_r1),
    .o_z_cen   (z_cen1),
    .o_z_oen   (z_oen1),
    .o_z_addr  (z_addr1),
    .i_z_rdata (rdata1),
    .i_z_r     (z_r1),
    .o_d_v     (d_v1),
    .o_d_d     (d_d1),
    .i_d_r     (d_r1)
  );

  cory_sram_rd_port #(.A(8), .D(32), .C(3)) u_dut2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_s_cen   (cen2),
    .i_s_oen   (oen2),
    .i_s_addr  (addr2),
    .o_s_r     (s_r2),
    .o_z_cen   (z_cen2),
    .o_z_oen   (z_oen2),
    .o_z_addr  (z_addr2),
    .i_z_rdata (rdata2),
    .i_z_r     (z_r2),
    .o_d_v     (d_v2),
    .o_d_d     (d_d2),
    .i_d_r     (d_r2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] f_data(input logic [7:0] a);
    return {8'hB0, a, ~a, 8'h3C};
  endfunction

  typedef struct {
    logic        cen;
    logic        oen;
    logic [7:0]  addr;
    logic        z_r;
    logic [31:0] rdata;
    logic        d_r;
    logic        e_s_r;
    logic        e_z_cen;
    logic        e_z_oen;
    logic        e_d_v;
    logic        chk_d;
    logic [31:0] e_d_d;
  } vec_t;

  function automatic vec_t mk(input logic cen, oen, input logic [7:0] addr,
                              input logic z_r, input logic [31:0] rdata,
                              input logic d_r, e_s_r, e_z_cen, e_z_oen, e_d_v,
                              input logic chk_d, input logic [31:0] e_d_d);
    vec_t v;
    v.cen = cen;     v.oen = oen;         v.addr = addr;
    v.z_r = z_r;     v.rdata = rdata;     v.d_r = d_r;
    v.e_s_r = e_s_r; v.e_z_cen = e_z_cen; v.e_z_oen = e_z_oen;
    v.e_d_v = e_d_v; v.chk_d = chk_d;     v.e_d_d = e_d_d;
    return v;
  endfunction

  localparam logic [31:0] D10 = 32'h1111_0010;
  localparam logic [31:0] D11 = 32'h1111_0011;
  localparam logic [31:0] D12 = 32'h1111_0012;
  localparam logic [31:0] D20 = 32'h2222_0020;
  localparam logic [31:0] D21 = 32'h2222_0021;

  vec_t vecs[22];

  initial begin
    // Columns: cen oen addr z_r rdata d_r | s_r z_cen z_oen d_v chk_d d_d
    // Single read of 0x05 returning 0xA5.
    vecs[0]  = mk(0, 1, 8'h05, 1, 32'h0,  1,  1, 0, 1, 0, 0, 32'h0);
    vecs[1]  = mk(1, 1, 8'h05, 1, 32'hA5, 1,  1, 1, 0, 0, 0, 32'h0);
    vecs[2]  = mk(1, 1, 8'h00, 1, 32'h0,  1,  1, 1, 1, 1, 1, 32'hA5);
    vecs[3]  = mk(1, 1, 8'h00, 1, 32'h0,  1,  1, 1, 1, 0, 0, 32'h0);
    // Consumer stalled: two accepted, then credit exhausted.
    vecs[4]  = mk(0, 1, 8'h10, 1, 32'h0,  0,  1, 0, 1, 0, 0, 32'h0);
    vecs[5]  = mk(0, 1, 8'h11, 1, D10,    0,  1, 0, 0, 0, 0, 32'h0);
    vecs[6]  = mk(0, 1, 8'h12, 1, D11,    0,  0, 1, 0, 1, 1, D10);
    vecs[7]  = mk(0, 1, 8'h12, 1, 32'h0,  0,  0, 1, 1, 1, 1, D10);
    // Ready rises: same-cycle credit return, issue and pop together.
    vecs[8]  = mk(0, 1, 8'h12, 1, 32'h0,  1,  1, 0, 1, 1, 1, D10);
    vecs[9]  = mk(1, 1, 8'h00, 1, D12,    0,  0, 1, 0, 1, 1, D11);
    vecs[10] = mk(1, 1, 8'h00, 1, 32'h0,  1,  1, 1, 1, 1, 1, D11);
    vecs[11] = mk(1, 1, 8'h00, 1, 32'h0,  1,  1, 1, 1, 1, 1, D12);
    vecs[12] = mk(1, 1, 8'h00, 1, 32'h0,  1,  1, 1, 1, 0, 0, 32'h0);
    // SRAM not ready for 3 cycles with a read in flight.
    vecs[13] = mk(0, 1, 8'h20, 1, 32'h0,  1,  1, 0, 1, 0, 0, 32'h0);
    vecs[14] = mk(0, 1, 8'h21, 0, D20,    1,  0, 0, 0, 0, 0, 32'h0);
    vecs[15] = mk(0, 1, 8'h21, 0, 32'h0,  1,  0, 0, 1, 1, 1, D20);
    vecs[16] = mk(0, 1, 8'h21, 0, 32'h0,  1,  0, 0, 1, 0, 0, 32'h0);
    vecs[17] = mk(0, 1, 8'h21, 1, 32'h0,  1,  1, 0, 1, 0, 0, 32'h0);
    vecs[18] = mk(1, 1, 8'h00, 1, D21,    1,  1, 1, 0, 0, 0, 32'h0);
    // Output-enable hint drives o_z_oen but never captures data.
    vecs[19] = mk(1, 0, 8'h00, 1, 32'h0,  1,  1, 1, 0, 1, 1, D21);
    vecs[20] = mk(1, 0, 8'h00, 1, 32'hDEAD, 1, 1, 1, 0, 0, 0, 32'h0);
    vecs[21] = mk(1, 1, 8'h00, 1, 32'h0,  1,  1, 1, 1, 0, 0, 32'h0);
  end

  initial begin
    int beats;
    int accepts;

    reset_n = 1'b0;
    cen1 = 1'b1; oen1 = 1'b1; addr1 = '0; z_r1 = 1'b1; rdata1 = '0; d_r1 = 1'b1;
    cen2 = 1'b1; oen2 = 1'b1; addr2 = '0; z_r2 = 1'b1; rdata2 = '0; d_r2 = 1'b1;

    // Reset state: enables pass through, nothing valid.
    #2;
    cen1 = 1'b0; z_r1 = 1'b0;
    #1;
    check("rst s_r(z_r=0)", 32'(s_r1),   32'h0);
    check("rst z_cen",      32'(z_cen1), 32'h0);
    check("rst z_oen",      32'(z_oen1), 32'h1);
    check("rst d_v",        32'(d_v1),   32'h0);
    check("rst d_v dut2",   32'(d_v2),   32'h0);
    z_r1 = 1'b1;
    #1;
    check("rst s_r(z_r=1)", 32'(s_r1),   32'h1);
    cen1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Vector table on u_dut1 (C=1).
    for (int i = 0; i < 22; i++) begin
      cen1 = vecs[i].cen;  oen1 = vecs[i].oen;     addr1 = vecs[i].addr;
      z_r1 = vecs[i].z_r;  rdata1 = vecs[i].rdata; d_r1 = vecs[i].d_r;
      @(negedge clk);
      check($sformatf("v%0d s_r", i),    32'(s_r1),   32'(vecs[i].e_s_r));
      check($sformatf("v%0d z_cen", i),  32'(z_cen1), 32'(vecs[i].e_z_cen));
      check($sformatf("v%0d z_oen", i),  32'(z_oen1), 32'(vecs[i].e_z_oen));
      check($sformatf("v%0d z_addr", i), 32'(z_addr1), 32'(vecs[i].addr));
      check($sformatf("v%0d d_v", i),    32'(d_v1),   32'(vecs[i].e_d_v));
      if (vecs[i].chk_d)
        check($sformatf("v%0d d_d", i), d_d1, vecs[i].e_d_d);
      @(posedge clk);
      #1;
    end

    // 16 back-to-back reads at full throughput, C=1.
    beats = 0;
    oen1 = 1'b1; z_r1 = 1'b1; d_r1 = 1'b1;
    for (int k = 0; k < 19; k++) begin
      cen1   = (k < 16) ? 1'b0 : 1'b1;
      addr1  = 8'(k);
      rdata1 = (k >= 1 && k <= 16) ? f_data(8'(k - 1)) : 32'h0;
      @(negedge clk);
      check($sformatf("burst%0d s_r", k), 32'(s_r1), 32'h1);
      if (k >= 2 && k <= 17) begin
        check($sformatf("burst%0d d_v", k), 32'(d_v1), 32'h1);
        check($sformatf("burst%0d d_d", k), d_d1, f_data(8'(k - 2)));
      end else begin
        check($sformatf("burst%0d d_v", k), 32'(d_v1), 32'h0);
      end
      if (d_v1) beats++;
      @(posedge clk);
      #1;
    end
    check("burst beat count", 32'(beats), 32'd16);

    // Reset with one beat queued and one read in flight.
    cen1 = 1'b0; addr1 = 8'h30; rdata1 = 32'h0;
    @(posedge clk); #1;
    cen1 = 1'b0; addr1 = 8'h31; rdata1 = f_data(8'h30); d_r1 = 1'b0;
    @(posedge clk); #1;
    cen1 = 1'b1; rdata1 = f_data(8'h31);
    check("pre-reset d_v", 32'(d_v1), 32'h1);
    reset_n = 1'b0;
    #1;
    check("mid-reset d_v",   32'(d_v1),   32'h0);
    check("mid-reset z_oen", 32'(z_oen1), 32'h1);
    check("mid-reset s_r",   32'(s_r1),   32'h1);
    d_r1 = 1'b1;
    @(posedge clk);
    #2 reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("post-reset%0d d_v", k), 32'(d_v1), 32'h0);
      @(posedge clk);
    end
    #1;

    // u_dut2 (C=3): latency of a single read.
    cen2 = 1'b0; addr2 = 8'h40; d_r2 = 1'b1; rdata2 = 32'h0;
    @(negedge clk);
    check("c3 t s_r",   32'(s_r2),   32'h1);
    check("c3 t z_cen", 32'(z_cen2), 32'h0);
    @(posedge clk); #1;
    cen2 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      rdata2 = (k == 3) ? f_data(8'h40) : 32'h0;
      @(negedge clk);
      check($sformatf("c3 t+%0d z_oen", k), 32'(z_oen2), (k == 3) ? 32'h0 : 32'h1);
      check($sformatf("c3 t+%0d d_v", k),   32'(d_v2),   (k == 4) ? 32'h1 : 32'h0);
      if (k == 4) check("c3 t+4 d_d", d_d2, f_data(8'h40));
      @(posedge clk); #1;
    end

    // u_dut2 credit limit: four accepted with the consumer stalled.
    accepts = 0;
    beats   = 0;
    for (int k = 0; k < 20; k++) begin
      cen2   = (k < 8) ? 1'b0 : 1'b1;
      d_r2   = (k >= 8) ? 1'b1 : 1'b0;
      addr2  = 8'h50 + 8'(k);
      rdata2 = f_data(8'h50 + 8'(k));
      @(negedge clk);
      if (k < 8) begin
        check($sformatf("c3 stall%0d s_r", k), 32'(s_r2), (k < 4) ? 32'h1 : 32'h0);
        if (s_r2) accepts++;
      end
      if (d_v2 && d_r2) begin
        check($sformatf("c3 drain beat%0d", beats), d_d2, f_data(8'h53 + 8'(beats)));
        beats++;
      end
      @(posedge clk); #1;
    end
    check("c3 accepted count", 32'(accepts), 32'd4);
    check("c3 drained count",  32'(beats),   32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cory_sram_rd_port
